// File: rtl/nibble_serial_subtractor.sv
// Purpose: WIDTH-bit serial subtractor, Diff = A - B, one nibble per clock (LSB first) via a 4-bit CLA slice on A and ~B.
// Latency: Start accepted at E0 -> Done pulses in the cycle after E_NIBBLES; next Start accepted at E_NIBBLES+2.
// Backpressure: Start is honoured only while Ready=1; Start in BUSY/DONE is ignored.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   Start, A, B         request and operands (captured on the accepting edge)
//   Ready               high only in IDLE (state decode)
//   Done                one-cycle completion pulse (state decode)
//   Diff, Bout, Ovf, Zero  registered result and flags, updated only on completion or reset
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] nb_sh;     // holds ~B so the slice is a plain adder
    logic [WIDTH-1:0] res_sh;
    logic             a_msb;
    logic             b_msb;

    // 4-bit carry-lookahead slice on the current low nibbles
    logic [3:0]       g, p, s;
    logic [4:0]       c;
    logic             last;
    logic [WIDTH+3:0] res_cat;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        g    = a_sh[3:0] & nb_sh[3:0];
        p    = a_sh[3:0] ^ nb_sh[3:0];
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    // New nibble enters at the top; after NIBBLES shifts the word is complete and aligned.
    assign res_cat = {s, res_sh};
    assign res_nxt = res_cat[WIDTH+3:4];
    assign last    = (cnt == CW'(NIBBLES - 1));

    assign Ready = (state == IDLE);
    assign Done  = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            nb_sh  <= '0;
            res_sh <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Ovf    <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh  <= A;
                        nb_sh <= ~B;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        carry <= 1'b1;   // +1 completes the two's complement of B
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 4;
                    nb_sh  <= nb_sh >> 4;
                    res_sh <= res_nxt;
                    carry  <= c[4];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Diff <= res_nxt;
                        Bout <= ~c[4];
                        Ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
                        Zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int W = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A, B;
    logic         Ready, Done;
    logic [W-1:0] Diff;
    logic         Bout, Ovf, Zero;

    int checks = 0;
    int passes = 0;
    res_t exp_q[$];
    res_t last_exp;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
        .Ready(Ready), .Done(Done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        int sa, sb, d;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d  = sa - sb;
        r.diff = a - b;
        r.bout = (a < b);
        r.ovf  = (d > 32767) || (d < -32768);
        r.zero = (r.diff == 0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_done: Done=1 with no outstanding operation at %0t", $time);
            end else begin
                res_t e;
                res_t got;
                e = exp_q.pop_front();
                got = '{diff: Diff, bout: Bout, ovf: Ovf, zero: Zero};
                if (got === e) passes++;
                else $display("FAIL result: got diff=%h bout=%b ovf=%b zero=%b expected diff=%h bout=%b ovf=%b zero=%b",
                              Diff, Bout, Ovf, Zero, e.diff, e.bout, e.ovf, e.zero);
            end
        end
    end

    // One operation; hold_start keeps Start high with junk operands during BUSY/DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
        int n;
        bit seen;
        @(negedge Clk);
        chk("ready_before_start", Ready, 1);
        A = a; B = b; Start = 1'b1;
        last_exp = model(a, b);
        exp_q.push_back(last_exp);
        @(posedge Clk);
        #1;
        if (hold_start) begin
            A = '1; B = '0;
        end else begin
            Start = 1'b0;
            A = W'($urandom); B = W'($urandom);
        end
        chk("ready_busy", Ready, 0);
        n = 0; seen = 0;
        while (n < 20 && !seen) begin
            @(posedge Clk);
            #1;
            n++;
            if (Done) seen = 1;
            else if (hold_start) begin
                A = W'($urandom); B = W'($urandom);
            end
        end
        if (!seen) $display("FAIL done_timeout: no Done within %0d cycles", n);
        chk("latency", n, NIB);
        chk("ready_done", Ready, 0);
        Start = 1'b0;
        @(posedge Clk);
        #1;
        chk("ready_after", Ready, 1);
        chk("done_single", Done, 0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_ready", Ready, 1);
        chk("rst_done", Done, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_flags", {Bout, Ovf, Zero}, 0);

        do_op(16'h1234, 16'h0034, 0);
        do_op(16'h0000, 16'h0001, 0);
        do_op(16'h8000, 16'h0001, 0);
        do_op(16'h7FFF, 16'hFFFF, 0);
        do_op(16'hABCD, 16'hABCD, 0);
        do_op(16'h1000, 16'h0001, 0);
        do_op(16'h0005, 16'h0003, 1);

        // Outputs hold while idle.
        repeat (3) @(posedge Clk);
        #1;
        chk("hold_diff", Diff, last_exp.diff);
        chk("hold_flags", {Bout, Ovf, Zero}, {last_exp.bout, last_exp.ovf, last_exp.zero});

        // Abort with reset sampled at E2.
        @(negedge Clk);
        A = 16'h5555; B = 16'h1111; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        chk("abort_ready", Ready, 1);
        chk("abort_done", Done, 0);
        chk("abort_diff", Diff, 0);
        chk("abort_flags", {Bout, Ovf, Zero}, 0);
        repeat (8) @(posedge Clk);
        #1;
        chk("abort_idle", Ready, 1);
        do_op(16'h5555, 16'h1111, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(posedge Clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
